xalu: RTL and testbench

Extended ALU for the MIPS pipeline: a multi-cycle multiply/divide unit that owns the HI and LO registers. Execute-stage instructions mult, multu, div and divu start an operation here. mthi and mtlo write the registers directly, and mfhi and mflo read them through XALUOUT. BUSY tells the hazard unit to stall any HI/LO-dependent instruction while a computation is in flight.

---
 rtl/xalu.sv | 202 ++++++++++++++++++++
 tb/tb_xalu.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xalu.sv
// ============================================================================
// Module   : xalu
// Brief    : Multi-cycle multiply/divide unit that owns the MIPS HI/LO
//            registers. Build option XALU_DIV0_HOLD_EN: a divide by zero
//            leaves HI/LO unchanged instead of writing LO=all-ones and HI=A.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xalu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  XALU_OP,
    input  logic        HI_WE,
    input  logic        LO_WE,
    input  logic        XALUOUT_sel,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [31:0] XALU_Wdata,
    output logic [31:0] XALUOUT,
    output logic        BUSY
);

    localparam int c_max_cycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_cnt_w      = $clog2(c_max_cycles + 1);

    localparam logic [c_cnt_w-1:0] c_mult_load = c_cnt_w'(MULT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_div_load  = c_cnt_w'(DIV_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(1);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_busy = 1'b1;

    localparam logic [1:0] c_op_mult  = 2'd0;
    localparam logic [1:0] c_op_multu = 2'd1;
    localparam logic [1:0] c_op_div   = 2'd2;
    localparam logic [1:0] c_op_divu  = 2'd3;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [1:0]         r_op;

    logic               w_op_valid;
    logic [1:0]         w_op_code;
    logic               w_start;
    logic               w_done;

    // ------------------------------------------------------------------------
    // Start decode: only the four exact one-hot encodings start an operation
    // ------------------------------------------------------------------------
    always_comb begin
        w_op_valid = 1'b1;
        w_op_code  = c_op_mult;
        case (XALU_OP)
            4'b0001: w_op_code = c_op_mult;
            4'b0010: w_op_code = c_op_multu;
            4'b0100: w_op_code = c_op_div;
            4'b1000: w_op_code = c_op_divu;
            default: w_op_valid = 1'b0;
        endcase
    end

    assign w_start = (r_state == c_st_idle) && w_op_valid;
    assign w_done  = (r_state == c_st_busy) && (r_cnt == c_cnt_last);

    // ------------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (w_start) w_state_nxt = c_st_busy;
            c_st_busy: if (w_done)  w_state_nxt = c_st_idle;
            default:                w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        BUSY    = (r_state == c_st_busy);
        XALUOUT = XALUOUT_sel ? r_lo : r_hi;
    end

    // ------------------------------------------------------------------------
    // Arithmetic on the latched operands. Signed forms are done on magnitudes
    // so one multiplier and one divider serve both signed and unsigned ops.
    // ------------------------------------------------------------------------
    logic        w_is_signed;
    logic        w_is_div;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [63:0] w_prod_mag;
    logic [63:0] w_prod;
    logic        w_div0;
    logic [31:0] w_divisor;
    logic [31:0] w_quo_mag;
    logic [31:0] w_rem_mag;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_hi_res;
    logic [31:0] w_lo_res;
    logic        w_res_we;

    assign w_is_signed = (r_op == c_op_mult) || (r_op == c_op_div);
    assign w_is_div    = (r_op == c_op_div)  || (r_op == c_op_divu);

    assign w_a_neg = w_is_signed & r_a[31];
    assign w_b_neg = w_is_signed & r_b[31];
    assign w_a_mag = w_a_neg ? (32'd0 - r_a) : r_a;
    assign w_b_mag = w_b_neg ? (32'd0 - r_b) : r_b;

    assign w_prod_mag = {32'd0, w_a_mag} * {32'd0, w_b_mag};
    assign w_prod     = (w_a_neg ^ w_b_neg) ? (64'd0 - w_prod_mag) : w_prod_mag;

    // The divisor is forced non-zero so the divider never sees x; the zero
    // case is resolved separately below.
    assign w_div0    = (r_b == 32'd0);
    assign w_divisor = w_div0 ? 32'd1 : w_b_mag;
    assign w_quo_mag = w_a_mag / w_divisor;
    assign w_rem_mag = w_a_mag % w_divisor;

    // Quotient truncates toward zero; remainder takes the dividend's sign.
    assign w_quo = (w_a_neg ^ w_b_neg) ? (32'd0 - w_quo_mag) : w_quo_mag;
    assign w_rem = w_a_neg ? (32'd0 - w_rem_mag) : w_rem_mag;

    always_comb begin
        w_res_we = 1'b1;
        w_hi_res = w_prod[63:32];
        w_lo_res = w_prod[31:0];
        if (w_is_div) begin
            if (w_div0) begin
`ifdef XALU_DIV0_HOLD_EN
                w_res_we = 1'b0;
                w_hi_res = r_hi;
                w_lo_res = r_lo;
`else
                w_hi_res = r_a;
                w_lo_res = 32'hFFFF_FFFF;
`endif
            end else begin
                w_hi_res = w_rem;
                w_lo_res = w_quo;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Counter, operand latches and HI/LO
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_a   <= 32'd0;
            r_b   <= 32'd0;
            r_op  <= c_op_mult;
        end else if (w_start) begin
            r_a   <= A;
            r_b   <= B;
            r_op  <= w_op_code;
            r_cnt <= ((w_op_code == c_op_div) || (w_op_code == c_op_divu)) ? c_div_load
                                                                           : c_mult_load;
        end else if (r_state == c_st_busy) begin
            r_cnt <= r_cnt - c_cnt_last;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_done) begin
            if (w_res_we) begin
                r_hi <= w_hi_res;
                r_lo <= w_lo_res;
            end
        end else if ((r_state == c_st_idle) && !w_op_valid) begin
            // A starting operation takes precedence over direct writes.
            if (HI_WE) r_hi <= XALU_Wdata;
            if (LO_WE) r_lo <= XALU_Wdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_xalu.sv
// ============================================================================
// Module   : tb_xalu
// Brief    : Directed self-checking bench for xalu.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xalu;

    logic        clk;
    logic        reset;
    logic [3:0]  XALU_OP;
    logic        HI_WE;
    logic        LO_WE;
    logic        XALUOUT_sel;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] XALU_Wdata;
    logic [31:0] XALUOUT;
    logic        BUSY;

    int n_checks;
    int n_fail;

    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0100;
    localparam logic [3:0] OP_DIVU  = 4'b1000;

    xalu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .XALU_OP    (XALU_OP),
        .HI_WE      (HI_WE),
        .LO_WE      (LO_WE),
        .XALUOUT_sel(XALUOUT_sel),
        .A          (A),
        .B          (B),
        .XALU_Wdata (XALU_Wdata),
        .XALUOUT    (XALUOUT),
        .BUSY       (BUSY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_hi(output logic [31:0] v);
        XALUOUT_sel = 1'b0;
        #1;
        v = XALUOUT;
    endtask

    task automatic read_lo(output logic [31:0] v);
        XALUOUT_sel = 1'b1;
        #1;
        v = XALUOUT;
    endtask

    // Count cycles BUSY stays high after issuing op; bounded at 50.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int cycles);
        XALU_OP = op;
        A = a;
        B = b;
        tick();
        XALU_OP = 4'b0000;
        cycles = 0;
        while (BUSY && cycles < 50) begin
            cycles++;
            tick();
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_checks++;
        if (BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected 0", BUSY);
        end
        read_hi(v);
        n_checks++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_hi: got %h expected 00000000", v);
        end
        read_lo(v);
        n_checks++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_lo: got %h expected 00000000", v);
        end
    endtask

    task automatic test_direct_write();
        logic [31:0] v;
        HI_WE = 1'b1;
        XALU_Wdata = 32'h1234;
        tick();
        tick();
        HI_WE = 1'b0;
        LO_WE = 1'b1;
        XALU_Wdata = 32'h5678;
        tick();
        LO_WE = 1'b0;
        read_hi(v);
        n_checks++;
        if (v !== 32'h0000_1234) begin
            n_fail++;
            $display("FAIL dw_hi: got %h expected 00001234", v);
        end
        read_lo(v);
        n_checks++;
        if (v !== 32'h0000_5678) begin
            n_fail++;
            $display("FAIL dw_lo: got %h expected 00005678", v);
        end
        // Simultaneous write of both registers.
        HI_WE = 1'b1;
        LO_WE = 1'b1;
        XALU_Wdata = 32'hA5A5_0F0F;
        tick();
        HI_WE = 1'b0;
        LO_WE = 1'b0;
        read_hi(v);
        n_checks++;
        if (v !== 32'hA5A5_0F0F) begin
            n_fail++;
            $display("FAIL dw_both_hi: got %h expected a5a50f0f", v);
        end
        read_lo(v);
        n_checks++;
        if (v !== 32'hA5A5_0F0F) begin
            n_fail++;
            $display("FAIL dw_both_lo: got %h expected a5a50f0f", v);
        end
    endtask

    task automatic test_arith(input string name, input logic [3:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input int exp_cyc, input logic [31:0] exp_hi,
                              input logic [31:0] exp_lo);
        int cyc;
        logic [31:0] v;
        run_op(op, a, b, cyc);
        n_checks++;
        if (cyc != exp_cyc) begin
            n_fail++;
            $display("FAIL %s_busy_cycles: got %0d expected %0d", name, cyc, exp_cyc);
        end
        read_hi(v);
        n_checks++;
        if (v !== exp_hi) begin
            n_fail++;
            $display("FAIL %s_hi: got %h expected %h", name, v, exp_hi);
        end
        read_lo(v);
        n_checks++;
        if (v !== exp_lo) begin
            n_fail++;
            $display("FAIL %s_lo: got %h expected %h", name, v, exp_lo);
        end
    endtask

    task automatic test_invalid_op();
        XALU_OP = 4'b0011;
        tick();
        XALU_OP = 4'b0000;
        n_checks++;
        if (BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL invalid_op_busy: got %b expected 0", BUSY);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] v;
        XALU_OP = OP_DIVU;
        A = 32'hCABB_FCA8;
        B = 32'h0000_1234;
        tick();
        XALU_OP = 4'b0000;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_busy: got %b expected 0", BUSY);
        end
        read_hi(v);
        n_checks++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_hi: got %h expected 00000000", v);
        end
        for (int i = 0; i < 15; i++) tick();
        read_lo(v);
        n_checks++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_lo_later: got %h expected 00000000", v);
        end
        n_checks++;
        if (BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_busy_later: got %b expected 0", BUSY);
        end
    endtask

    task automatic test_start_drops_write();
        logic [31:0] v;
        int cyc;
        HI_WE = 1'b1;
        LO_WE = 1'b1;
        XALU_Wdata = 32'h0000_0055;
        run_op(OP_MULT, 32'd2, 32'd3, cyc);
        HI_WE = 1'b0;
        LO_WE = 1'b0;
        read_hi(v);
        n_checks++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL startwr_hi: got %h expected 00000000", v);
        end
        read_lo(v);
        n_checks++;
        if (v !== 32'h6) begin
            n_fail++;
            $display("FAIL startwr_lo: got %h expected 00000006", v);
        end
    endtask

    task automatic test_div0();
        logic [31:0] v;
        int cyc;
        HI_WE = 1'b1;
        LO_WE = 1'b1;
        XALU_Wdata = 32'h0000_AAAA;
        tick();
        HI_WE = 1'b0;
        LO_WE = 1'b0;
        XALU_OP = OP_DIV;
        A = 32'h0000_0007;
        B = 32'h0;
        tick();
        XALU_OP = 4'b0000;
        // Direct write attempts while busy must be ignored.
        HI_WE = 1'b1;
        XALU_Wdata = 32'hDEAD_BEEF;
        cyc = 0;
        while (BUSY && cyc < 50) begin
            cyc++;
            tick();
        end
        HI_WE = 1'b0;
        n_checks++;
        if (cyc != 10) begin
            n_fail++;
            $display("FAIL div0_busy_cycles: got %0d expected 10", cyc);
        end
        read_hi(v);
        n_checks++;
`ifdef XALU_DIV0_HOLD_EN
        if (v !== 32'h0000_AAAA) begin
            n_fail++;
            $display("FAIL div0_hi: got %h expected 0000aaaa", v);
        end
`else
        if (v !== 32'h0000_0007) begin
            n_fail++;
            $display("FAIL div0_hi: got %h expected 00000007", v);
        end
`endif
        read_lo(v);
        n_checks++;
`ifdef XALU_DIV0_HOLD_EN
        if (v !== 32'h0000_AAAA) begin
            n_fail++;
            $display("FAIL div0_lo: got %h expected 0000aaaa", v);
        end
`else
        if (v !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL div0_lo: got %h expected ffffffff", v);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        int cyc;
        XALU_OP = OP_MULTU;
        A = 32'd3;
        B = 32'd4;
        tick();
        // Operands changed while busy must not affect the running op.
        A = 32'd5;
        B = 32'd6;
        cyc = 0;
        while (BUSY && cyc < 50) begin
            cyc++;
            tick();
        end
        n_checks++;
        if (cyc != 5) begin
            n_fail++;
            $display("FAIL b2b_first_cycles: got %0d expected 5", cyc);
        end
        read_lo(v);
        n_checks++;
        if (v !== 32'd12) begin
            n_fail++;
            $display("FAIL b2b_first_lo: got %h expected 0000000c", v);
        end
        // Op still held: restart on this idle edge with the new operands.
        tick();
        XALU_OP = 4'b0000;
        n_checks++;
        if (BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_restart_busy: got %b expected 1", BUSY);
        end
        cyc = 0;
        while (BUSY && cyc < 50) begin
            cyc++;
            tick();
        end
        read_lo(v);
        n_checks++;
        if (v !== 32'd30) begin
            n_fail++;
            $display("FAIL b2b_second_lo: got %h expected 0000001e", v);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        XALU_OP     = 4'b0000;
        HI_WE       = 1'b0;
        LO_WE       = 1'b0;
        XALUOUT_sel = 1'b0;
        A           = 32'h0;
        B           = 32'h0;
        XALU_Wdata  = 32'h0;

        test_reset();
        test_direct_write();
        test_invalid_op();
        test_arith("mult",  OP_MULT,  32'h0000_1234, 32'hCABB_FCA8, 5,
                   32'hFFFF_FC36, 32'h65F3_2220);
        test_arith("multu", OP_MULTU, 32'hCABB_FCA8, 32'h0000_1234, 5,
                   32'h0000_0E6A, 32'h65F3_2220);
        test_arith("div",   OP_DIV,   32'hCABB_FCA8, 32'h0000_1234, 10,
                   32'hFFFF_F9F0, 32'hFFFD_12E6);
        test_arith("divu",  OP_DIVU,  32'hCABB_FCA8, 32'h0000_1234, 10,
                   32'h0000_0888, 32'h000B_2328);
        test_arith("mult_neg", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,
                   32'h0000_0000, 32'h0000_0001);
        test_arith("div_negdiv", OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 10,
                   32'h0000_0001, 32'hFFFF_FFFD);
        test_reset_mid_op();
        test_start_drops_write();
        test_div0();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
